// File: rtl/scan_sel_seq_pkg.sv
// Purpose : shared state encoding and default widths for the scan select sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: IN_DEF (index width), DWELL_W_DEF (dwell count width), state_t (IDLE/SCAN/STOPPING).
package scan_sel_seq_pkg;

   localparam int IN_DEF      = 3;
   localparam int DWELL_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SCAN     = 2'd1,
      STOPPING = 2'd2
   } state_t;

endpackage

// File: rtl/scan_next_idx.sv
// Purpose : circular priority search for the next active position strictly after cur.
// Latency : purely combinational, zero cycles.
// Backpressure: none; no handshake.
// Ports: cur   - current index
//        mask  - active-position bits (bit i = position i)
//        nxt   - next active index after cur, circular; equals cur when only cur is active
//        wrap  - search went around (nxt <= cur)
//        any   - at least one position is active
module scan_next_idx
   import scan_sel_seq_pkg::*;
#(
   parameter int IN = IN_DEF
) (
   input  logic [IN-1:0]      cur,
   input  logic [(1<<IN)-1:0] mask,
   output logic [IN-1:0]      nxt,
   output logic               wrap,
   output logic               any
);

   localparam int N = 1 << IN;

   logic [IN-1:0] cand;

   // Walk offsets from the farthest (N, i.e. cur itself) down to the nearest (1);
   // the last hit wins, so the closest active position after cur is kept.
   always_comb begin
      nxt  = cur;
      cand = cur;
      for (int k = N; k >= 1; k--) begin
         cand = cur + IN'(k);
         if (mask[cand]) begin
            nxt = cand;
         end
      end
      wrap = (nxt <= cur);
      any  = |mask;
   end

endmodule

// File: rtl/scan_sel_seq.sv
// Purpose : steps a decoder select index through active positions, holding each dwell+1 cycles.
// Latency : start sampled at edge N gives sel/enable/busy in cycle N+1; all outputs registered.
// Backpressure: none; free-running once started, stop drains the current dwell before going idle.
// Ports: clk, rst_n (async active-low); start, stop, dwell, mask inputs;
//        sel/enable drive decoder in/enable, busy = not idle, wrap = one-cycle wrap-around pulse.
// Build option: SCAN_SEL_SEQ_MASK_EN honours mask; otherwise every position is active.
module scan_sel_seq
   import scan_sel_seq_pkg::*;
#(
   parameter int IN      = IN_DEF,
   parameter int DWELL_W = DWELL_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                stop,
   input  logic [DWELL_W-1:0]  dwell,
   input  logic [(1<<IN)-1:0]  mask,
   output logic [IN-1:0]       sel,
   output logic                enable,
   output logic                busy,
   output logic                wrap
);

   state_t               state;
   logic [DWELL_W-1:0]   cnt;

   logic [(1<<IN)-1:0]   eff_mask;
   logic [IN-1:0]        search_cur;
   logic [IN-1:0]        nxt_idx;
   logic                 nxt_wrap;
   logic                 any_active;

`ifdef SCAN_SEL_SEQ_MASK_EN
   assign eff_mask = mask;
`else
   // mask port kept for pin compatibility; its value is deliberately ignored here
   logic mask_unused;
   assign mask_unused = ^mask;
   assign eff_mask    = '1;
`endif

   // From IDLE, searching after the top index lands on the lowest active one,
   // so a single search block serves both the initial load and the advance.
   assign search_cur = (state == IDLE) ? '1 : sel;

   scan_next_idx #(.IN(IN)) u_next (
      .cur  (search_cur),
      .mask (eff_mask),
      .nxt  (nxt_idx),
      .wrap (nxt_wrap),
      .any  (any_active)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         sel    <= '0;
         enable <= 1'b0;
         busy   <= 1'b0;
         wrap   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               wrap <= 1'b0;
               if (start && any_active) begin
                  state  <= SCAN;
                  sel    <= nxt_idx;
                  cnt    <= dwell;
                  enable <= 1'b1;
                  busy   <= 1'b1;
               end
            end
            SCAN: begin
               if (cnt == '0) begin
                  // Dwell just expired: a stop or an empty mask ends here
                  // instead of advancing.
                  if (stop || !any_active) begin
                     state  <= IDLE;
                     sel    <= '0;
                     cnt    <= '0;
                     enable <= 1'b0;
                     busy   <= 1'b0;
                     wrap   <= 1'b0;
                  end else begin
                     sel  <= nxt_idx;
                     cnt  <= dwell;
                     wrap <= nxt_wrap;
                  end
               end else begin
                  cnt  <= cnt - DWELL_W'(1);
                  wrap <= 1'b0;
                  if (stop) begin
                     state <= STOPPING;
                  end
               end
            end
            STOPPING: begin
               wrap <= 1'b0;
               if (cnt == '0) begin
                  state  <= IDLE;
                  sel    <= '0;
                  enable <= 1'b0;
                  busy   <= 1'b0;
               end else begin
                  cnt <= cnt - DWELL_W'(1);
               end
            end
            default: begin
               state  <= IDLE;
               sel    <= '0;
               cnt    <= '0;
               enable <= 1'b0;
               busy   <= 1'b0;
               wrap   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scan_sel_seq.sv
// Purpose : self-checking bench for scan_sel_seq (vector table plus hand-written corner sequences).
// Latency : each vector drives inputs, then checks outputs 1 ns after the next rising edge.
// Backpressure: n/a.
// Expected outputs follow SCAN_SEL_SEQ_MASK_EN when the mask matters.
module tb_scan_sel_seq;

   typedef struct packed {
      logic [2:0] sel;
      logic       en;
      logic       busy;
      logic       wrap;
   } out_t;

   typedef struct {
      logic       start;
      logic       stop;
      logic [7:0] dwell;
      logic [7:0] mask;
      out_t       exp;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic [7:0] dwell;
   logic [7:0] mask;
   logic [2:0] sel;
   logic       enable;
   logic       busy;
   logic       wrap;

   int   nvec;
   int   nerr;
   out_t sb[$];
   vec_t tbl[22];

   scan_sel_seq #(.IN(3), .DWELL_W(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .stop   (stop),
      .dwell  (dwell),
      .mask   (mask),
      .sel    (sel),
      .enable (enable),
      .busy   (busy),
      .wrap   (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic out_t o(input int s, input bit e, input bit b, input bit w);
      out_t r;
      r.sel  = 3'(s);
      r.en   = e;
      r.busy = b;
      r.wrap = w;
      return r;
   endfunction

   task automatic check(input string tag);
      out_t got;
      out_t want;
      got = {sel, enable, busy, wrap};
      if (sb.size() == 0) begin
         nerr++;
         $display("FAIL %s: scoreboard empty, got sel=%0d en=%b busy=%b wrap=%b", tag, sel, enable, busy, wrap);
      end else begin
         want = sb.pop_front();
         nvec++;
         if (got !== want) begin
            nerr++;
            $display("FAIL %s: got sel=%0d en=%b busy=%b wrap=%b, expected sel=%0d en=%b busy=%b wrap=%b",
                     tag, got.sel, got.en, got.busy, got.wrap, want.sel, want.en, want.busy, want.wrap);
         end
      end
   endtask

   // Drive one cycle of inputs, queue the expected outputs, check after the edge.
   task automatic apply(input logic s, input logic p, input logic [7:0] d, input logic [7:0] m,
                        input out_t e, input string tag);
      start = s;
      stop  = p;
      dwell = d;
      mask  = m;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check(tag);
   endtask

   initial begin : main
      int on_sel[5];
      bit on_wrap[5];
      out_t idle;
      idle = o(0, 0, 0, 0);
      nvec = 0;
      nerr = 0;

      // ---- vector table: full dwell=0 scan, stop at expiry, dwell changes mid-step ----
      tbl[0]  = '{1'b0, 1'b0, 8'd0, 8'hFF, idle};
      tbl[1]  = '{1'b1, 1'b1, 8'd0, 8'hFF, o(0, 1, 1, 0)};   // start+stop in IDLE: start wins
      for (int i = 2; i <= 8; i++)
         tbl[i] = '{1'b0, 1'b0, 8'd0, 8'hFF, o(i - 1, 1, 1, 0)};
      tbl[9]  = '{1'b0, 1'b0, 8'd0, 8'hFF, o(0, 1, 1, 1)};   // 7 -> 0 wrap
      tbl[10] = '{1'b0, 1'b1, 8'd0, 8'hFF, idle};            // stop as dwell expires
      tbl[11] = '{1'b1, 1'b0, 8'd1, 8'hFF, o(0, 1, 1, 0)};
      tbl[12] = '{1'b0, 1'b0, 8'd1, 8'hFF, o(0, 1, 1, 0)};
      tbl[13] = '{1'b0, 1'b0, 8'd1, 8'hFF, o(1, 1, 1, 0)};
      tbl[14] = '{1'b0, 1'b0, 8'd3, 8'hFF, o(1, 1, 1, 0)};   // new dwell not applied to sel=1
      tbl[15] = '{1'b0, 1'b0, 8'd3, 8'hFF, o(2, 1, 1, 0)};
      tbl[16] = '{1'b0, 1'b0, 8'd0, 8'hFF, o(2, 1, 1, 0)};   // sel=2 keeps dwell 3
      tbl[17] = '{1'b1, 1'b0, 8'd0, 8'hFF, o(2, 1, 1, 0)};   // start ignored in SCAN
      tbl[18] = '{1'b1, 1'b0, 8'd0, 8'hFF, o(2, 1, 1, 0)};
      tbl[19] = '{1'b0, 1'b0, 8'd0, 8'hFF, o(3, 1, 1, 0)};
      tbl[20] = '{1'b0, 1'b0, 8'd0, 8'hFF, o(4, 1, 1, 0)};
      tbl[21] = '{1'b0, 1'b1, 8'd0, 8'hFF, idle};

      rst_n = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      dwell = 8'd0;
      mask  = 8'hFF;
      #12;
      sb.push_back(idle);
      check("reset_state");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 22; i++)
         apply(tbl[i].start, tbl[i].stop, tbl[i].dwell, tbl[i].mask, tbl[i].exp, $sformatf("tbl[%0d]", i));

      // ---- full scan, dwell=2: every position 3 cycles, wrap on return to 0, then stop ----
      apply(1, 0, 8'd2, 8'hFF, o(0, 1, 1, 0), "full_k0");
      for (int k = 1; k <= 24; k++)
         apply(0, 0, 8'd2, 8'hFF, o((k / 3) % 8, 1, 1, k == 24), $sformatf("full_k%0d", k));
      apply(0, 1, 8'd2, 8'hFF, o(0, 1, 1, 0), "full_stop0");
      apply(0, 0, 8'd2, 8'hFF, o(0, 1, 1, 0), "full_stop1");
      apply(0, 0, 8'd2, 8'hFF, idle, "full_stop_idle");
      apply(0, 0, 8'd2, 8'hFF, idle, "full_stay_idle");

      // ---- stop on 2nd cycle of sel=3 with dwell=4: sel=3 held 5 cycles, no advance ----
      apply(1, 0, 8'd4, 8'hFF, o(0, 1, 1, 0), "stop_k0");
      for (int k = 1; k <= 16; k++)
         apply(0, 0, 8'd4, 8'hFF, o(k / 5, 1, 1, 0), $sformatf("stop_k%0d", k));
      apply(0, 1, 8'd4, 8'hFF, o(3, 1, 1, 0), "stop_req");
      apply(0, 1, 8'd4, 8'hFF, o(3, 1, 1, 0), "stop_hold1");
      apply(0, 0, 8'd4, 8'hFF, o(3, 1, 1, 0), "stop_hold2");
      apply(0, 0, 8'd4, 8'hFF, idle, "stop_done");
      apply(0, 1, 8'd4, 8'hFF, idle, "stop_idle");

      // ---- mask skip, dwell=0 ----
`ifdef SCAN_SEL_SEQ_MASK_EN
      on_sel  = '{2, 5, 7, 2, 5};
      on_wrap = '{0, 0, 0, 1, 0};
`else
      on_sel  = '{0, 1, 2, 3, 4};
      on_wrap = '{0, 0, 0, 0, 0};
`endif
      for (int k = 0; k < 5; k++)
         apply(k == 0, 0, 8'd0, 8'hA4, o(on_sel[k], 1, 1, on_wrap[k]), $sformatf("skip_k%0d", k));
      apply(0, 1, 8'd0, 8'hA4, idle, "skip_stop");

      // ---- single active position, dwell=1, then mask -> 0 mid-dwell ----
      for (int k = 0; k < 5; k++) begin
`ifdef SCAN_SEL_SEQ_MASK_EN
         apply(k == 0, 0, 8'd1, 8'h10, o(4, 1, 1, (k > 0) && (k % 2 == 0)), $sformatf("single_k%0d", k));
`else
         apply(k == 0, 0, 8'd1, 8'h10, o(k / 2, 1, 1, 0), $sformatf("single_k%0d", k));
`endif
      end
`ifdef SCAN_SEL_SEQ_MASK_EN
      apply(0, 0, 8'd1, 8'h00, o(4, 1, 1, 0), "single_mask0_finish");
      apply(0, 0, 8'd1, 8'h00, idle, "single_mask0_idle");
      apply(0, 1, 8'd1, 8'h00, idle, "single_idle1");
      apply(0, 0, 8'd1, 8'h00, idle, "single_idle2");
`else
      apply(0, 0, 8'd1, 8'h00, o(2, 1, 1, 0), "single_mask0_finish");
      apply(0, 0, 8'd1, 8'h00, o(3, 1, 1, 0), "single_mask0_next");
      apply(0, 1, 8'd1, 8'h00, o(3, 1, 1, 0), "single_stop");
      apply(0, 0, 8'd1, 8'h00, idle, "single_idle2");
`endif

      // ---- start with mask=0 ----
`ifdef SCAN_SEL_SEQ_MASK_EN
      apply(1, 0, 8'd0, 8'h00, idle, "mask0_start");
`else
      apply(1, 0, 8'd0, 8'h00, o(0, 1, 1, 0), "mask0_start");
`endif
      apply(0, 1, 8'd0, 8'h00, idle, "mask0_after");

      // ---- asynchronous reset while sel=5 ----
      apply(1, 0, 8'd0, 8'hFF, o(0, 1, 1, 0), "rst_k0");
      for (int k = 1; k <= 5; k++)
         apply(0, 0, 8'd0, 8'hFF, o(k, 1, 1, 0), $sformatf("rst_k%0d", k));
      #2;
      rst_n = 1'b0;
      #1;
      sb.push_back(idle);
      check("rst_async");
      @(posedge clk);
      #1;
      sb.push_back(idle);
      check("rst_held");
      rst_n = 1'b1;
      apply(0, 0, 8'd0, 8'hFF, idle, "rst_release_idle");
      apply(1, 0, 8'd0, 8'hFF, o(0, 1, 1, 0), "rst_restart");
      apply(0, 0, 8'd0, 8'hFF, o(1, 1, 1, 0), "rst_restart_adv");
      apply(0, 1, 8'd0, 8'hFF, idle, "rst_restart_stop");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/scan_sel_seq.md
# scan_sel_seq

Sequential index generator that drives the select and enable inputs of the 3-to-8 decoder stage. On start it steps a 3-bit index through the active positions in ascending circular order, holding each for a programmable dwell, and asserts enable while an index is valid. Typical use: row/digit scanning in front of `decoder_3_8`; `sel`/`enable` connect directly to the decoder's `in`/`enable`.

## Interface
- `IN`, 3: index width; number of positions is 2**IN
- `DWELL_W`, 8: width of dwell count
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous active-low reset
- `start`  input  1  begin scanning; sampled in IDLE only
- `stop`  input  1  request graceful stop; sampled in SCAN only
- `dwell`  input  DWELL_W  hold count; each position held dwell+1 cycles
- `mask`  input  2**IN  position-enable bits (bit i = position i active)
- `sel`  output  IN  current index, to decoder `in`
- `enable`  output  1  index valid, to decoder `enable`
- `busy`  output  1  state != IDLE
- `wrap`  output  1  one-cycle pulse on circular wrap-around

Clock and reset are fixed: one clock `clk`; reset `rst_n` is asynchronous, active-low.

## Operation
- States: IDLE, SCAN, STOPPING.
- IDLE: `sel`=0, `enable`=0, `busy`=0. On `start`=1 (and effective mask nonzero) -> SCAN; `sel` loads lowest active index, dwell counter loads `dwell`.
- SCAN: `enable`=1. Counter decrements each cycle; at 0, advance: `sel` <- next active index strictly after current, circular; counter reloads current `dwell` value.
- Wrap: when the advance yields index <= current (including single-active-position case), `wrap`=1 for the cycle the new `sel` appears.
- `stop`=1 in SCAN -> STOPPING; current position completes its dwell, then -> IDLE (no further advance, `wrap` not pulsed). `enable` stays 1 through STOPPING.
- `start` ignored outside IDLE; `stop` ignored outside SCAN. Simultaneous `start`+`stop` in IDLE: start wins.
- Effective mask all zero: `start` ignored in IDLE; if it becomes zero during SCAN/STOPPING, finish current dwell then -> IDLE.
- Changing `dwell` mid-step has no effect until the next reload.
- `dwell`=0: advance every cycle.

## Timing
- Reset: `sel`=0, `enable`=0, `busy`=0, `wrap`=0, state IDLE, counter 0; asynchronous assertion aborts any scan immediately.
- Start latency: `start` high at edge N -> `sel`/`enable`/`busy` valid after edge N (visible cycle N+1).
- Each position visible exactly dwell+1 cycles; all outputs registered, no combinational input-to-output path.
- Stop: `enable`/`busy` fall on the edge at which the current dwell expires.

## Configuration
- `SCAN_SEL_SEQ_MASK_EN` defined: `mask` honoured; inactive positions skipped, zero-mask rules apply.
- Not defined: `mask` ignored, effective mask all ones; sequence 0..2**IN-1 with wrap after 2**IN-1; port remains present.

## Structure
- Package `scan_sel_seq_pkg`: state encoding constants (IDLE=0, SCAN=1, STOPPING=2), default widths.
- Sub-module `scan_next_idx`: combinational circular priority search (current index, mask -> next index, wrap flag, any-active); top holds FSM, counter, output registers.

## Test plan
- Reset mid-scan: assert `rst_n`=0 while `sel`=5 -> all outputs 0 asynchronously; IDLE after release.
- Full scan, mask=8'hFF, dwell=2: `sel` 0,1,...,7 each 3 cycles, `wrap` pulse as `sel` returns to 0.
- Mask skip (macro on), mask=8'b1010_0100, dwell=0: `sel` 2,5,7,2,... one cycle each, `wrap` on 7->2; macro off: 0..7.
- Stop mid-dwell: dwell=4, `stop` on 2nd cycle of `sel`=3 -> `sel`=3 held 5 cycles total, then `enable`/`busy`=0, no advance.
- Single active position mask=8'h10, dwell=1: `sel`=4 continuously, `wrap` every 2 cycles; mask->0 mid-scan -> IDLE after current dwell.
- Edge cases: `start` with mask=0 -> stays IDLE; `start`+`stop` together in IDLE -> scan begins; `dwell` change mid-step takes effect on next position only.
